// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq: the master side issues start/bin_in,
// the slave side (the converter) returns busy, done and the display fields.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, blank
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, blank
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_BLANK_EN to build the leading-zero blank mask; otherwise blank is 0.
module bin2bcd_seq #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bin2bcd_seq_if.slave    bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift;
  logic [SW-1:0]    scratch_q, scratch_d, scratch_adj, scratch_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             done_q, done_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             carry;

  // Add-3 correction ahead of the shift keeps every digit within 0..9.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  assign {carry, scratch_shift, shreg_shift} = {scratch_adj, shreg_q, 1'b0};

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_shift;
        scratch_d = scratch_shift;
        cnt_d     = cnt_q + CW'(1);
        ovf_acc_d = ovf_acc_q | carry;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = scratch_shift;
          ovf_d   = ovf_acc_q | carry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_final;
  logic              all_zero;

  // A digit blanks only if it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    blank_final = '0;
    all_zero    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero       = all_zero & (scratch_shift[4*i +: 4] == 4'd0);
      blank_final[i] = all_zero;
    end
    blank_d = done_d ? blank_final : blank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq: a 4-digit and a 3-digit
// instance checked against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

  localparam int WIDTH = 13;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(4)) bus4 ();
  bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(3)) bus3 ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_cmp = 0;
  int n_bad = 0;

  // Decimal digits of v modulo 10^d, overflow flag and leading-zero mask.
  function automatic void ref_model(input int v, input int d, output logic [15:0] bcd,
                                    output logic ovf, output logic [3:0] blank);
    int lim, r, t, p;
    lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    r     = v % lim;
    ovf   = (v >= lim);
    bcd   = '0;
    blank = '0;
    t     = r;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BCD_BLANK_EN
    p = 10;
    for (int k = 1; k < d; k++) begin
      blank[k] = (r < p);
      p = p * 10;
    end
`else
    p = 0;
`endif
  endfunction

  // Runs one conversion on the 4-digit instance. poke_kind 1 pulses start with
  // poke_val at busy cycle poke_cyc; poke_kind 2 pulses reset there instead.
  task automatic convert4(input int v, input int poke_cyc, input int poke_kind, input int poke_val,
                          output int done_cyc, output int done_cnt, output int busy_cnt,
                          output logic busy_after, output logic [15:0] bcd_after);
    done_cyc   = -1;
    done_cnt   = 0;
    busy_cnt   = 0;
    busy_after = 1'bx;
    bcd_after  = 'x;
    bus4.bin_in = 13'(v);
    bus4.start  = 1'b1;
    @(negedge clk);
    bus4.start  = 1'b0;
    bus4.bin_in = 13'($urandom);
    for (int cyc = 1; cyc <= WIDTH + 5; cyc++) begin
      if (bus4.busy === 1'b1) busy_cnt++;
      if (bus4.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == poke_cyc + 1) begin
        busy_after = bus4.busy;
        bcd_after  = bus4.bcd_out;
        bus4.start = 1'b0;
        reset      = 1'b0;
      end
      if (cyc == poke_cyc && poke_kind == 1) begin
        bus4.start  = 1'b1;
        bus4.bin_in = 13'(poke_val);
      end
      if (cyc == poke_cyc && poke_kind == 2) reset = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic check_result4(input string name, input int v, input int done_cyc,
                               input int done_cnt, input int busy_cnt);
    logic [15:0] e_bcd;
    logic        e_ovf;
    logic [3:0]  e_blank;
    ref_model(v, 4, e_bcd, e_ovf, e_blank);
    n_cmp++;
    if (bus4.bcd_out !== e_bcd) begin
      n_bad++;
      $display("FAIL %s bcd_out v=%0d: got %h want %h", name, v, bus4.bcd_out, e_bcd);
    end
    n_cmp++;
    if (bus4.overflow !== e_ovf) begin
      n_bad++;
      $display("FAIL %s overflow v=%0d: got %b want %b", name, v, bus4.overflow, e_ovf);
    end
    n_cmp++;
    if (bus4.blank !== e_blank) begin
      n_bad++;
      $display("FAIL %s blank v=%0d: got %b want %b", name, v, bus4.blank, e_blank);
    end
    n_cmp++;
    if (done_cyc != WIDTH + 1 || done_cnt != 1 || busy_cnt != WIDTH) begin
      n_bad++;
      $display("FAIL %s timing v=%0d: got done_cyc=%0d dones=%0d busy=%0d want %0d/1/%0d",
               name, v, done_cyc, done_cnt, busy_cnt, WIDTH + 1, WIDTH);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus4.start  = 1'b0;
    bus4.bin_in = '0;
    bus3.start  = 1'b0;
    bus3.bin_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus4.busy, bus4.done, bus4.bcd_out, bus4.overflow, bus4.blank} !== '0) begin
      n_bad++;
      $display("FAIL reset4: got busy=%b done=%b bcd=%h ovf=%b blank=%b want all 0",
               bus4.busy, bus4.done, bus4.bcd_out, bus4.overflow, bus4.blank);
    end
    n_cmp++;
    if ({bus3.busy, bus3.done, bus3.bcd_out, bus3.overflow, bus3.blank} !== '0) begin
      n_bad++;
      $display("FAIL reset3: got busy=%b done=%b bcd=%h ovf=%b blank=%b want all 0",
               bus3.busy, bus3.done, bus3.bcd_out, bus3.overflow, bus3.blank);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int dc, dn, bc;
    logic ba;
    logic [15:0] bb;
    convert4(1234, 0, 0, 0, dc, dn, bc, ba, bb);
    check_result4("latency", 1234, dc, dn, bc);
  endtask

  task automatic test_boundaries();
    int vals[6] = '{0, 8191, 9, 10, 42, 1000};
    int dc, dn, bc;
    logic ba;
    logic [15:0] bb;
    foreach (vals[i]) begin
      convert4(vals[i], 0, 0, 0, dc, dn, bc, ba, bb);
      check_result4("boundary", vals[i], dc, dn, bc);
    end
  endtask

  task automatic test_random();
    int dc, dn, bc, v;
    logic ba;
    logic [15:0] bb;
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(8191, 0));
      convert4(v, 0, 0, 0, dc, dn, bc, ba, bb);
      check_result4("random", v, dc, dn, bc);
    end
  endtask

  task automatic test_start_ignored();
    int dc, dn, bc;
    logic ba;
    logic [15:0] bb;
    convert4(5678, 5, 1, 321, dc, dn, bc, ba, bb);
    check_result4("start_while_busy", 5678, dc, dn, bc);
  endtask

  task automatic test_reset_abort();
    int dc, dn, bc;
    logic ba;
    logic [15:0] bb;
    convert4(2468, 7, 2, 0, dc, dn, bc, ba, bb);
    n_cmp++;
    if (ba !== 1'b0 || bb !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_abort after: got busy=%b bcd=%h want 0/0000", ba, bb);
    end
    n_cmp++;
    if (dn != 0 || bc != 7) begin
      n_bad++;
      $display("FAIL reset_abort pulses: got dones=%0d busy=%0d want 0/7", dn, bc);
    end
    convert4(4321, 0, 0, 0, dc, dn, bc, ba, bb);
    check_result4("after_abort", 4321, dc, dn, bc);
  endtask

  task automatic test_back_to_back();
    int          t_done[$];
    logic [15:0] r_done[$];
    int          t0, t1;
    logic [15:0] r0, r1;
    bus4.bin_in = 13'd100;
    bus4.start  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus4.bin_in = 13'd4321;
      if (bus4.done === 1'b1) begin
        t_done.push_back(cyc);
        r_done.push_back(bus4.bcd_out);
        if (t_done.size() == 2) bus4.start = 1'b0;
      end
    end
    bus4.start = 1'b0;
    t0 = (t_done.size() > 0) ? t_done[0] : -1;
    t1 = (t_done.size() > 1) ? t_done[1] : -1;
    r0 = (r_done.size() > 0) ? r_done[0] : 16'hxxxx;
    r1 = (r_done.size() > 1) ? r_done[1] : 16'hxxxx;
    n_cmp++;
    if (t_done.size() != 2 || t0 != WIDTH + 1 || t1 != 2 * (WIDTH + 1)) begin
      n_bad++;
      $display("FAIL back_to_back timing: got %0d dones at %0d,%0d want 2 at %0d,%0d",
               t_done.size(), t0, t1, WIDTH + 1, 2 * (WIDTH + 1));
    end
    n_cmp++;
    if (r0 !== 16'h0100 || r1 !== 16'h4321) begin
      n_bad++;
      $display("FAIL back_to_back data: got %h,%h want 0100,4321", r0, r1);
    end
  endtask

  task automatic test_three_digits();
    int vals[$] = '{1500, 999, 1000, 0, 42};
    int v, dc;
    logic [15:0] e_bcd;
    logic        e_ovf;
    logic [3:0]  e_blank;
    for (int i = 0; i < 8; i++) vals.push_back(int'($urandom_range(8191, 0)));
    foreach (vals[i]) begin
      v  = vals[i];
      dc = -1;
      bus3.bin_in = 13'(v);
      bus3.start  = 1'b1;
      @(negedge clk);
      bus3.start = 1'b0;
      for (int cyc = 1; cyc <= WIDTH + 5; cyc++) begin
        if (bus3.done === 1'b1 && dc < 0) dc = cyc;
        @(negedge clk);
      end
      ref_model(v, 3, e_bcd, e_ovf, e_blank);
      n_cmp++;
      if ({4'h0, bus3.bcd_out} !== e_bcd || bus3.overflow !== e_ovf) begin
        n_bad++;
        $display("FAIL digits3 v=%0d: got bcd=%h ovf=%b want %h/%b",
                 v, bus3.bcd_out, bus3.overflow, e_bcd[11:0], e_ovf);
      end
      n_cmp++;
      if ({1'b0, bus3.blank} !== e_blank || dc != WIDTH + 1) begin
        n_bad++;
        $display("FAIL digits3 blank/timing v=%0d: got blank=%b done_cyc=%0d want %b/%0d",
                 v, bus3.blank, dc, e_blank[2:0], WIDTH + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_three_digits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
